// File: rtl/demux_drive_ctrl.sv
// -----------------------------------------------------------------------------
// demux_drive_ctrl
//
// Sequencer in front of a 4-way NAND-gate demultiplexer slice. Requests
// (data bit, destination lane) are accepted over a valid/ready handshake,
// buffered in a small FIFO, and presented to the demux with break-before-make
// timing. The select lines only change while the demux data input is low, so
// the gate-level slice never glitches onto an unintended lane.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered occupancy (count < DEPTH), never on
// in_valid. The producer holds in_data/in_dest stable while in_valid is high.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//   HOLD       cycles dmx_a is asserted per entry (>= 1)
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   FIFO can accept (count < DEPTH)
//   in_data    bit to steer
//   in_dest    destination lane 0..3
//   dmx_a      registered demux data input
//   dmx_s      registered demux select
//   done       one-cycle pulse when an entry finishes its drive phase
//   busy       FSM not idle, or FIFO not empty
//   count      FIFO occupancy
//   scan_req   lamp-test sweep request (only with DEMUX_SCAN_EN)
//   dbg_state  current FSM state, for observation only
//
// Optional feature: define DEMUX_SCAN_EN to add the scan_req input and the
// lamp-test sweep states. With the macro undefined the block has no scan
// logic at all.
// -----------------------------------------------------------------------------
module demux_drive_ctrl #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_data,
  input  logic [1:0]             in_dest,
  output logic                   dmx_a,
  output logic [1:0]             dmx_s,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
`ifdef DEMUX_SCAN_EN
  input  logic                   scan_req,
`endif
  output logic [2:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Hold counter counts down from HOLD-1 to 0; keep at least one bit.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SETUP      = 3'd1;
  localparam logic [2:0] ST_DRIVE      = 3'd2;
`ifdef DEMUX_SCAN_EN
  localparam logic [2:0] ST_SCAN_SETUP = 3'd3;
  localparam logic [2:0] ST_SCAN_DRIVE = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage: entry = {data, dest}
  // ---------------------------------------------------------------------------
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;
  logic [2:0]    head;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_data, in_dest};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide and DEPTH is a power of 2, so the natural
  // binary overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic          dmx_a_q, dmx_a_d;
  logic [1:0]    dmx_s_q, dmx_s_d;
  logic          done_q,  done_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic          data_q,  data_d;   // data bit of the entry being presented
`ifdef DEMUX_SCAN_EN
  logic [1:0]    lane_q,  lane_d;   // lane being lit during the sweep
`endif

  always_comb begin
    state_d = state_q;
    dmx_a_d = dmx_a_q;
    dmx_s_d = dmx_s_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef DEMUX_SCAN_EN
    lane_d  = lane_q;
`endif

    case (state_q)
      ST_IDLE: begin
        dmx_a_d = 1'b0;
        if (count_q != '0) begin
          // dmx_a is already low, so the select may move on this edge.
          pop     = 1'b1;
          dmx_s_d = head[1:0];
          data_d  = head[2];
          state_d = ST_SETUP;
        end
`ifdef DEMUX_SCAN_EN
        else if (scan_req) begin
          lane_d  = 2'd0;
          dmx_s_d = 2'd0;
          state_d = ST_SCAN_SETUP;
        end
`endif
      end

      ST_SETUP: begin
        // One settle cycle with the new select and a low data input.
        dmx_a_d = data_q;
        hold_d  = HW'(HOLD - 1);
        state_d = ST_DRIVE;
      end

      ST_DRIVE: begin
        if (hold_q == '0) begin
          // dmx_a falls on this edge, so loading the next select here
          // still respects break-before-make.
          dmx_a_d = 1'b0;
          done_d  = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            dmx_s_d = head[1:0];
            data_d  = head[2];
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

`ifdef DEMUX_SCAN_EN
      ST_SCAN_SETUP: begin
        dmx_a_d = 1'b1;
        hold_d  = HW'(HOLD - 1);
        state_d = ST_SCAN_DRIVE;
      end

      ST_SCAN_DRIVE: begin
        if (hold_q == '0) begin
          dmx_a_d = 1'b0;
          if (lane_q == 2'd3) begin
            // Queued requests are picked up from IDLE on the next edge.
            state_d = ST_IDLE;
          end else begin
            lane_d  = lane_q + 2'd1;
            dmx_s_d = lane_q + 2'd1;
            state_d = ST_SCAN_SETUP;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
`endif

      default: begin
        dmx_a_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dmx_a_q <= 1'b0;
      dmx_s_q <= 2'd0;
      done_q  <= 1'b0;
      hold_q  <= '0;
      data_q  <= 1'b0;
`ifdef DEMUX_SCAN_EN
      lane_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      dmx_a_q <= dmx_a_d;
      dmx_s_q <= dmx_s_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
`ifdef DEMUX_SCAN_EN
      lane_q  <= lane_d;
`endif
    end
  end

  assign dmx_a     = dmx_a_q;
  assign dmx_s     = dmx_s_q;
  assign done      = done_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE) || (count_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_demux_drive_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for demux_drive_ctrl. Two instances share clock and reset:
//   u_h1 : DEPTH=4, HOLD=1
//   u_h3 : DEPTH=4, HOLD=3
// Every accepted request goes into an expected queue. On each done pulse the
// monitor pops the oldest request and checks the waveform that preceded it:
// one cycle with dmx_a=0 and dmx_s=dest, then HOLD cycles of dmx_a=data with
// dmx_s=dest, then dmx_a=0 at the pulse. Select changes must coincide with
// dmx_a=0.
// -----------------------------------------------------------------------------
module tb_demux_drive_ctrl;

  logic clk;
  logic rst_n;
  logic scan_req;

  logic       in_valid1, in_data1, in_ready1, a1, done1, busy1;
  logic [1:0] in_dest1, s1;
  logic [2:0] cnt1, st1;

  logic       in_valid3, in_data3, in_ready3, a3, done3, busy3;
  logic [1:0] in_dest3, s3;
  logic [2:0] cnt3, st3;

  demux_drive_ctrl #(.DEPTH(4), .HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_dest(in_dest1), .dmx_a(a1), .dmx_s(s1),
    .done(done1), .busy(busy1), .count(cnt1),
`ifdef DEMUX_SCAN_EN
    .scan_req(scan_req),
`endif
    .dbg_state(st1)
  );

  demux_drive_ctrl #(.DEPTH(4), .HOLD(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_dest(in_dest3), .dmx_a(a3), .dmx_s(s3),
    .done(done3), .busy(busy3), .count(cnt3),
`ifdef DEMUX_SCAN_EN
    .scan_req(scan_req),
`endif
    .dbg_state(st3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];    // {data, dest} for u_h1
  logic [2:0] exp3_q[$];   // {data, dest} for u_h3
  int         done_cyc[$]; // cycles of u_h1 done pulses
  logic       ha [2][8];
  logic [1:0] hs [2][8];
  int         hv [2];
  logic       saw_full3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_step(input int id, input int h, input logic a, input logic [1:0] s,
                          input logic dn, input logic rdy, input logic [2:0] cnt);
    logic [2:0] e;
    int qsz;
    qsz = (id == 0) ? exp_q.size() : exp3_q.size();
    check("ready_vs_count", 32'(rdy), 32'(cnt < 3'd4));
    if (dn) begin
      if (id == 0) done_cyc.push_back(cyc);
      if (qsz == 0) begin
        check("done_without_request", 32'(qsz), 1);
      end else begin
        e = (id == 0) ? exp_q.pop_front() : exp3_q.pop_front();
        check("done_history_len", 32'(hv[id] >= h + 1), 1);
        check("done_a_low", 32'(a), 0);
        for (int i = 0; i < h; i++) begin
          check("drive_a", 32'(ha[id][i]), 32'(e[2]));
          check("drive_s", 32'(hs[id][i]), 32'(e[1:0]));
        end
        check("setup_a", 32'(ha[id][h]), 0);
        check("setup_s", 32'(hs[id][h]), 32'(e[1:0]));
      end
    end
    if (hv[id] > 0 && s != hs[id][0]) check("break_before_make", 32'(a), 0);
    if (id == 1 && cnt == 3'd4 && !rdy) saw_full3 = 1'b1;
    for (int i = 7; i > 0; i--) begin
      ha[id][i] = ha[id][i-1];
      hs[id][i] = hs[id][i-1];
    end
    ha[id][0] = a;
    hs[id][0] = s;
    if (hv[id] < 8) hv[id]++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hv[0] = 0;
      hv[1] = 0;
    end else begin
      mon_step(0, 1, a1, s1, done1, in_ready1, cnt1);
      mon_step(1, 3, a3, s3, done3, in_ready3, cnt3);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input int id, input logic d, input logic [1:0] dst);
    int n;
    logic ok;
    n = 0;
    if (id == 0) begin
      in_valid1 = 1'b1; in_data1 = d; in_dest1 = dst;
      while (!in_ready1 && n < 100) begin @(negedge clk); n++; end
      ok = in_ready1;
    end else begin
      in_valid3 = 1'b1; in_data3 = d; in_dest3 = dst;
      while (!in_ready3 && n < 100) begin @(negedge clk); n++; end
      ok = in_ready3;
    end
    check("send_ready_timeout", 32'(ok), 1);
    if (ok) begin
      if (id == 0) exp_q.push_back({d, dst});
      else         exp3_q.push_back({d, dst});
      @(negedge clk);
    end
    if (id == 0) in_valid1 = 1'b0;
    else         in_valid3 = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (((id == 0) ? (busy1 || exp_q.size() != 0) : (busy3 || exp3_q.size() != 0)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 300), 1);
    check("drain_count_zero", (id == 0) ? 32'(cnt1) : 32'(cnt3), 0);
    check("drain_queue_empty", (id == 0) ? 32'(exp_q.size()) : 32'(exp3_q.size()), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  int   n_a, n_d;
  logic any_a, any_d;

  initial begin
    rst_n = 1'b0; scan_req = 1'b0;
    in_valid1 = 1'b0; in_data1 = 1'b0; in_dest1 = 2'd0;
    in_valid3 = 1'b0; in_data3 = 1'b0; in_dest3 = 2'd0;
    saw_full3 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_a", 32'(a1), 0);
    check("rst_s", 32'(s1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_count", 32'(cnt1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_ready", 32'(in_ready1), 1);
    check("rst_a_h3", 32'(a3), 0);
    check("rst_ready_h3", 32'(in_ready3), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single push (1,2), HOLD=1: exact latency
    in_valid1 = 1'b1; in_data1 = 1'b1; in_dest1 = 2'd2;
    exp_q.push_back({1'b1, 2'd2});
    @(negedge clk);                       // after push edge k
    in_valid1 = 1'b0;
    check("single_count_k", 32'(cnt1), 1);
    check("single_a_k", 32'(a1), 0);
    @(negedge clk);                       // after k+1
    check("single_s_k1", 32'(s1), 2);
    check("single_a_k1", 32'(a1), 0);
    check("single_busy_k1", 32'(busy1), 1);
    @(negedge clk);                       // after k+2
    check("single_a_k2", 32'(a1), 1);
    check("single_done_k2", 32'(done1), 0);
    @(negedge clk);                       // after k+3
    check("single_a_k3", 32'(a1), 0);
    check("single_done_k3", 32'(done1), 1);
    check("single_busy_k3", 32'(busy1), 0);
    @(negedge clk);
    check("single_done_k4", 32'(done1), 0);

    // Back-to-back: one entry every 2 cycles, in order
    done_cyc.delete();
    send(0, 1'b1, 2'd0);
    send(0, 1'b1, 2'd1);
    send(0, 1'b0, 2'd2);
    send(0, 1'b1, 2'd3);
    send(0, 1'b1, 2'd0);
    drain(0);
    check("b2b_done_count", 32'(done_cyc.size()), 5);
    for (int i = 1; i < done_cyc.size(); i++)
      check("b2b_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 2);

    // HOLD=3, push (1,3): three high cycles, one done
    send(1, 1'b1, 2'd3);
    n_a = 0; n_d = 0;
    repeat (12) begin
      if (a3) n_a++;
      if (done3) n_d++;
      @(negedge clk);
    end
    check("hold3_high_cycles", 32'(n_a), 3);
    check("hold3_done_pulses", 32'(n_d), 1);
    drain(1);

    // Fill, stall on full, and wrap the pointers (9 entries, DEPTH=4)
    saw_full3 = 1'b0;
    for (int i = 0; i < 9; i++)
      send(1, 1'(($urandom_range(0, 3) != 0) ? 1 : 0), 2'($urandom_range(0, 3)));
    drain(1);
    check("fill_saw_full", 32'(saw_full3), 1);

    // Reset during DRIVE with 3 entries queued
    send(1, 1'b1, 2'd0);
    send(1, 1'b0, 2'd1);
    send(1, 1'b1, 2'd2);
    send(1, 1'b1, 2'd3);
    check("midrst_pre_drive", 32'(a3), 1);
    check("midrst_pre_count", 32'(cnt3), 3);
    rst_n = 1'b0;
    #1;
    check("midrst_a", 32'(a3), 0);
    check("midrst_s", 32'(s3), 0);
    check("midrst_count", 32'(cnt3), 0);
    check("midrst_ready", 32'(in_ready3), 1);
    check("midrst_busy", 32'(busy3), 0);
    check("midrst_done", 32'(done3), 0);
    exp_q.delete();
    exp3_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_a = 1'b0; any_d = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (a3) any_a = 1'b1;
      if (done3) any_d = 1'b1;
    end
    check("midrst_no_stale_drive", 32'(any_a), 0);
    check("midrst_no_done", 32'(any_d), 0);

    // Random traffic on HOLD=1 instance
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
